// File: rtl/gen_clk_param.sv
// gen_clk_param: base divider feeding a binary phase chain of gated, frame-aligned divided clocks.
module gen_clk_param #(
  parameter int N_OUT   = 3,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_val,
  input  logic [N_OUT-1:0] ch_en,
  output logic [N_OUT-1:0] clk_out,
  output logic [N_OUT-1:0] stb_out,
  output logic             locked,
  output logic [CNT_W-1:0] div_cur
);
  logic [CNT_W-1:0] cnt, pend_v;
  logic             pend, term, fb;
  logic [N_OUT-1:0] ph, g, ph_n, g_n, clk_n;
  // ph counts down, so each bit toggles exactly when all lower bits are 0
  always_comb begin
    term  = enb && (cnt == div_cur - 1'b1);
    fb    = term && (ph == '0);
    ph_n  = term ? ph - 1'b1 : ph;
    g_n   = (g & ph) | (ch_en & ~ph);
    clk_n = ph_n & g_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ph      <= '0;
      g       <= '0;
      clk_out <= '0;
      stb_out <= '0;
      locked  <= 1'b0;
      div_cur <= CNT_W'(DEF_DIV);
      pend    <= 1'b0;
      pend_v  <= CNT_W'(DEF_DIV);
    end else begin
      g       <= g_n;
      ph      <= ph_n;
      clk_out <= clk_n;
      stb_out <= clk_n & ~clk_out;
      cnt     <= term ? '0 : (enb ? cnt + 1'b1 : cnt);
      if (fb && pend) div_cur <= pend_v;
      if (div_ld) begin
        pend   <= 1'b1;
        pend_v <= (div_val == '0) ? CNT_W'(1) : div_val;
      end else if (fb) pend <= 1'b0;
      locked <= div_ld ? 1'b0 : (fb ? 1'b1 : locked);
    end
  end
endmodule

// File: tb/tb_gen_clk_param.sv
// tb_gen_clk_param: randomized scoreboard bench against an arithmetic frame/phase model.
module tb_gen_clk_param;
  localparam int N = 3;
  localparam int W = 8;
  localparam int DEF = 2;
  typedef struct {
    logic [N-1:0] co;
    logic [N-1:0] st;
    logic         lk;
    logic [W-1:0] dc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, enb = 1'b0, div_ld = 1'b0;
  logic [W-1:0] div_val = '0;
  logic [N-1:0] ch_en = '0;
  logic [N-1:0] clk_out, stb_out;
  logic locked;
  logic [W-1:0] div_cur;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int e = 0, d = DEF, pv = DEF;
  bit pend = 0, m_lk = 0;
  logic [N-1:0] m_g = '0, m_clk = '0;

  gen_clk_param #(.N_OUT(N), .CNT_W(W), .DEF_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .enb(enb), .div_ld(div_ld), .div_val(div_val),
    .ch_en(ch_en), .clk_out(clk_out), .stb_out(stb_out), .locked(locked), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  // phase vector after e enabled cycles: ph = -(terminals so far) mod 2^N
  function automatic logic [N-1:0] phase(int ec, int dv);
    int t;
    t = ec / dv;
    return N'(((1 << N) - (t % (1 << N))) % (1 << N));
  endfunction

  task automatic model();
    exp_t x;
    logic [N-1:0] ph, g_new;
    bit term, fb;
    if (rst) begin
      e = 0; d = DEF; pend = 0; m_g = '0; m_clk = '0; m_lk = 0;
      x.st = '0;
    end else begin
      ph = phase(e, d);
      term = enb && ((e + 1) % d == 0);
      fb = term && (ph == '0);
      for (int i = 0; i < N; i++) g_new[i] = ph[i] ? m_g[i] : ch_en[i];
      m_g = g_new;
      if (enb) e = e + 1;
      if (fb && pend) begin d = pv; e = d; end
      if (div_ld) begin pend = 1; pv = (div_val == 0) ? 1 : int'(div_val); end
      else if (fb) pend = 0;
      m_lk = div_ld ? 0 : (fb ? 1 : m_lk);
      x.st = (phase(e, d) & m_g) & ~m_clk;
      m_clk = phase(e, d) & m_g;
    end
    x.co = m_clk; x.lk = m_lk; x.dc = W'(d);
    q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic en, input logic ld, input logic [W-1:0] v, input logic [N-1:0] ch);
    @(negedge clk);
    rst = r; enb = en; div_ld = ld; div_val = v; ch_en = ch;
    model();
  endtask

  task automatic run(input int n, input logic [N-1:0] ch);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, ch);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("clk_out", W'(clk_out), W'(x.co));
      chk("stb_out", W'(stb_out), W'(x.st));
      chk("locked", W'(locked), W'(x.lk));
      chk("div_cur", div_cur, x.dc);
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 9, 3'b111);
    run(40, 3'b111);
    cyc(0, 1, 1, 5, 3'b111);
    run(100, 3'b111);
    cyc(0, 1, 1, 0, 3'b111);
    run(30, 3'b111);
    cyc(0, 1, 1, 3, 3'b111);
    run(3, 3'b111);
    cyc(0, 1, 1, 7, 3'b111);
    run(130, 3'b111);
    run(60, 3'b101);
    run(60, 3'b111);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 3'b111);
    run(30, 3'b111);
    cyc(0, 1, 1, 4, 3'b111);
    run(3, 3'b111);
    cyc(1, 1, 0, 0, 3'b111);
    run(60, 3'b111);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ch;
      ch = (i % 10 == 0) ? N'($urandom) : ch_en;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 85),
          ($urandom_range(0, 39) == 0), W'($urandom_range(0, 6)), ch);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gen_clk_param.md
GEN_CLK_PARAM -- requirements
Module: gen_clk_param

Interface
REQ-001 SHALL have parameter N_OUT, default 3: number of divided clock outputs, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 8: width of the base divide counter and of the divide value.
REQ-003 SHALL have parameter DEF_DIV, default 2: base divide value applied after reset, legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port enb, input, 1 bit: count enable; low freezes the counter, phases and outputs.
REQ-007 SHALL have port div_ld, input, 1 bit: one-cycle request to load div_val.
REQ-008 SHALL have port div_val, input, CNT_W bits: requested base divide value.
REQ-009 SHALL have port ch_en, input, N_OUT bits: per-channel output enable.
REQ-010 SHALL have port clk_out, output, N_OUT bits: registered, gated divided clocks.
REQ-011 SHALL have port stb_out, output, N_OUT bits: one-cycle pulse marking each rising edge of clk_out.
REQ-012 SHALL have port locked, output, 1 bit: high while the applied divide value is stable and aligned.
REQ-013 SHALL have port div_cur, output, CNT_W bits: the divide value currently applied.

Function
REQ-014 SHALL hold a base counter cnt that, when enb=1, increments each cycle and wraps to 0 at the terminal count, where terminal means cnt == div_cur-1.
REQ-015 SHALL keep an internal N_OUT-bit phase vector ph; at each terminal count, ph[i] toggles if and only if ph[0..i-1] are all 0, and ph[0] always toggles.
REQ-016 SHALL give ph[i] a period of 2^(i+1)*div_cur enabled cycles at 50% duty.
REQ-017 SHALL define a frame boundary as a terminal count with ph all 0, on which all ph bits rise together.
REQ-018 SHALL capture div_val into a pending register on div_ld=1 regardless of enb; div_val=0 SHALL be stored as 1; if several loads arrive before application, the last one wins.
REQ-019 SHALL apply a pending value only at a frame boundary: div_cur takes the pending value, cnt restarts at 0, and the pending flag clears.
REQ-020 SHALL, when div_ld coincides with a frame boundary, apply the previously pending value (if any) at that boundary and hold the new value pending for the next boundary.
REQ-021 SHALL drop locked to 0 in the cycle after div_ld and raise it on the frame boundary where no value remains pending.
REQ-022 SHALL keep a gate register g[i] per channel, loaded from ch_en[i] only in cycles where ph[i]=0, so that gating never truncates a high phase.
REQ-023 SHALL compute clk_out[i] as ph[i] AND g[i], registered with no combinational path from inputs.
REQ-024 SHALL pulse stb_out[i] for exactly one cycle, coincident with the cycle in which clk_out[i] goes 0 to 1.
REQ-025 SHALL, while enb=0, hold cnt, ph, clk_out and locked, keep stb_out at 0, and continue to update the gate registers.
REQ-026 SHALL produce glitch-free outputs: each clk_out bit changes at most once per clk cycle and only at terminal counts or through a gate change.

Reset
REQ-027 SHALL, on rst=1, reset cnt to 0, ph to 0, g to 0, clk_out to 0, stb_out to 0, locked to 0, div_cur to DEF_DIV, and clear the pending flag.
REQ-028 SHALL give rst priority over enb and div_ld in the same cycle; rst asserted mid-operation SHALL discard any pending value.
REQ-029 SHALL raise locked at the first frame boundary after reset.

Verification
REQ-030 Reset then enb=1, ch_en=3'b111, defaults -> clk_out=3'b111 and locked=1 after the 2nd edge; clk_out[0]/[1]/[2] periods of 4/8/16 cycles; stb_out pulses one cycle per rise.
REQ-031 div_ld with div_val=5 mid-frame -> locked=0 next cycle; div_cur stays 2 until the frame boundary, then becomes 5; periods become 10/20/40; locked=1 at that boundary.
REQ-032 div_ld with div_val=0 -> div_cur=1 after the boundary; clk_out[0] toggles every enabled cycle; two loads (3 then 7) in one frame -> only 7 applied.
REQ-033 ch_en[1] dropped while clk_out[1]=1 -> clk_out[1] completes its high phase, then stays 0 with no stb_out[1]; re-enable -> resumes on a rising edge aligned to ph[1].
REQ-034 enb low for 5 cycles mid-period -> all outputs frozen and stb_out=0; on resume, the remaining high/low time is preserved exactly.
REQ-035 rst asserted with a load pending -> all outputs 0 and div_cur=DEF_DIV; the pending value is never applied.
